// File: rtl/heater_ctrl_pkg.sv
// Shared definitions for the heater regulator: state encoding, default
// parameter values and the saturating threshold helpers.
package heater_ctrl_pkg;

  localparam int DEF_AVG_LOG2    = 2;
  localparam int DEF_MIN_HOLD    = 48000;
  localparam int DEF_WDOG_CYCLES = 4800000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HEAT  = 2'd1,
    ST_COOL  = 2'd2,
    ST_FAULT = 2'd3
  } heater_state_e;

  // Lower switching threshold: setpoint minus half-band, clamped at zero.
  function automatic logic [15:0] band_lo(input logic [15:0] setpoint,
                                          input logic [7:0]  half_band);
    logic [16:0] diff;
    diff = {1'b0, setpoint} - {9'b0, half_band};
    return diff[16] ? 16'h0000 : diff[15:0];
  endfunction

  // Upper switching threshold: setpoint plus half-band, clamped at full scale.
  function automatic logic [15:0] band_hi(input logic [15:0] setpoint,
                                          input logic [7:0]  half_band);
    logic [16:0] sum;
    sum = {1'b0, setpoint} + {9'b0, half_band};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/heater_ctrl_adc_boxcar.sv
// Boxcar averager: sums 2^AVG_LOG2 ADC samples and publishes their mean
// with a one-cycle strobe in the cycle after the last sample of a block.
module adc_boxcar
  import heater_ctrl_pkg::*;
#(
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic        clk48mhz,
  input  logic        rstn,
  input  logic        sample_valid,
  input  logic [15:0] adc_value,
  output logic [15:0] avg_value,
  output logic        avg_valid
);

  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [15:0]      avg_reg, avg_next;
  logic             valid_reg, valid_next;

  // Accumulate each qualified sample; on the block's last sample emit the mean and restart.
  always_comb begin
    sum        = acc_reg + ACC_W'(adc_value);
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    avg_next   = avg_reg;
    valid_next = 1'b0;
    if (sample_valid) begin
      if (cnt_reg == LAST_IDX) begin
        avg_next   = sum[ACC_W-1:AVG_LOG2];
        valid_next = 1'b1;
        acc_next   = '0;
        cnt_next   = '0;
      end else begin
        acc_next = sum;
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  // Register the running sum and output; reset drops any partial block.
  always_ff @(posedge clk48mhz) begin
    if (!rstn) begin
      acc_reg   <= '0;
      cnt_reg   <= '0;
      avg_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      avg_reg   <= avg_next;
      valid_reg <= valid_next;
    end
  end

  assign avg_value = avg_reg;
  assign avg_valid = valid_reg;

endmodule

// File: rtl/heater_ctrl.sv
// Bang-bang heater regulator with hysteresis and minimum on/off hold time.
// Averaged ADC readings drive an IDLE/HEAT/COOL state machine.
// Optional build macro HEATER_CTRL_WDOG_EN adds a sample watchdog that
// forces the FAULT state when the ADC stream stalls during regulation.
module heater_ctrl
  import heater_ctrl_pkg::*;
#(
  parameter int AVG_LOG2    = DEF_AVG_LOG2,
  parameter int MIN_HOLD    = DEF_MIN_HOLD,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic        clk48mhz,
  input  logic        rstn,
  input  logic        sample_valid,
  input  logic [15:0] adc_value,
  input  logic [15:0] adc_setpoint,
  input  logic [7:0]  hyst,
  input  logic        enable,
  output logic        heater_on,
  output logic [15:0] avg_value,
  output logic        avg_valid,
  output logic        fault
);

  localparam int HOLD_W = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);

  heater_state_e     state_reg, state_next;
  logic              heater_reg, heater_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic              hold_done;
  logic [15:0]       avg_int;
  logic              avg_strobe;
  logic [15:0]       thr_lo, thr_hi;
  logic              wdog_expired;

  adc_boxcar #(
    .AVG_LOG2(AVG_LOG2)
  ) u_boxcar (
    .clk48mhz    (clk48mhz),
    .rstn        (rstn),
    .sample_valid(sample_valid),
    .adc_value   (adc_value),
    .avg_value   (avg_int),
    .avg_valid   (avg_strobe)
  );

  assign thr_lo    = band_lo(adc_setpoint, hyst);
  assign thr_hi    = band_hi(adc_setpoint, hyst);
  assign hold_done = (hold_reg == HOLD_MAX);

  // Next-state decision: disable wins, then watchdog, then threshold crossings.
  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (avg_strobe) state_next = (avg_int < thr_lo) ? ST_HEAT : ST_COOL;
        end
        ST_HEAT: begin
          if (wdog_expired)                                   state_next = ST_FAULT;
          else if (avg_strobe && avg_int >= thr_hi && hold_done) state_next = ST_COOL;
        end
        ST_COOL: begin
          if (wdog_expired)                                   state_next = ST_FAULT;
          else if (avg_strobe && avg_int < thr_lo && hold_done)  state_next = ST_HEAT;
        end
        ST_FAULT: state_next = ST_FAULT;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Heater follows the next state; the hold timer restarts on every heater edge.
  always_comb begin
    heater_next = (state_next == ST_HEAT);
    hold_next   = hold_reg;
    if (heater_next != heater_reg) hold_next = '0;
    else if (!hold_done)           hold_next = hold_reg + HOLD_W'(1);
  end

  // State, heater drive and hold timer registers.
  always_ff @(posedge clk48mhz) begin
    if (!rstn) begin
      state_reg  <= ST_IDLE;
      heater_reg <= 1'b0;
      hold_reg   <= HOLD_MAX;
    end else begin
      state_reg  <= state_next;
      heater_reg <= heater_next;
      hold_reg   <= hold_next;
    end
  end

`ifdef HEATER_CTRL_WDOG_EN
  localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] wdog_reg, wdog_next;
  logic            wdog_running;
  logic            fault_reg;

  assign wdog_running = (state_reg == ST_HEAT) || (state_reg == ST_COOL);
  assign wdog_expired = wdog_running && !sample_valid && (wdog_reg == WD_LAST);

  // Count sample-free cycles while regulating; clear on a sample or when leaving HEAT/COOL.
  always_comb begin
    wdog_next = '0;
    if (wdog_running && !sample_valid &&
        (state_next == ST_HEAT || state_next == ST_COOL))
      wdog_next = wdog_reg + WD_W'(1);
  end

  // Watchdog counter and fault flag registers.
  always_ff @(posedge clk48mhz) begin
    if (!rstn) begin
      wdog_reg  <= '0;
      fault_reg <= 1'b0;
    end else begin
      wdog_reg  <= wdog_next;
      fault_reg <= (state_next == ST_FAULT);
    end
  end

  assign fault = fault_reg;
`else
  assign wdog_expired = 1'b0;
  assign fault        = 1'b0;
`endif

  assign heater_on = heater_reg;
  assign avg_value = avg_int;
  assign avg_valid = avg_strobe;

endmodule

// File: tb/tb_heater_ctrl.sv
// Self-checking bench for heater_ctrl: directed scenarios followed by a
// randomized phase, all compared cycle by cycle against a behavioural model.
module tb_heater_ctrl;

  localparam int AVG_LOG2    = 2;
  localparam int MIN_HOLD    = 8;
  localparam int WDOG_CYCLES = 100;
  localparam int NSAMP       = 1 << AVG_LOG2;
`ifdef HEATER_CTRL_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_HEAT  = 1;
  localparam int M_COOL  = 2;
  localparam int M_FAULT = 3;

  logic        clk48mhz = 1'b0;
  logic        rstn;
  logic        sample_valid;
  logic [15:0] adc_value;
  logic [15:0] adc_setpoint;
  logic [7:0]  hyst;
  logic        enable;
  logic        heater_on;
  logic [15:0] avg_value;
  logic        avg_valid;
  logic        fault;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_mode;
  bit m_heat;
  int m_since;
  int m_quiet;
  int m_q[$];
  int m_avg;
  bit m_avgv;

  always #5 clk48mhz = ~clk48mhz;

  heater_ctrl #(
    .AVG_LOG2   (AVG_LOG2),
    .MIN_HOLD   (MIN_HOLD),
    .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .clk48mhz    (clk48mhz),
    .rstn        (rstn),
    .sample_valid(sample_valid),
    .adc_value   (adc_value),
    .adc_setpoint(adc_setpoint),
    .hyst        (hyst),
    .enable      (enable),
    .heater_on   (heater_on),
    .avg_value   (avg_value),
    .avg_valid   (avg_valid),
    .fault       (fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic model_edge();
    int lo, hi, nxt, qc, sum;
    bit run_old;
    if (!rstn) begin
      m_mode = M_IDLE; m_heat = 0; m_since = MIN_HOLD; m_quiet = 0;
      m_q.delete(); m_avg = 0; m_avgv = 0;
      return;
    end
    lo = int'(adc_setpoint) - int'(hyst);
    if (lo < 0) lo = 0;
    hi = int'(adc_setpoint) + int'(hyst);
    if (hi > 65535) hi = 65535;
    run_old = (m_mode == M_HEAT) || (m_mode == M_COOL);
    qc  = (run_old && !sample_valid) ? m_quiet + 1 : 0;
    nxt = m_mode;
    if (!enable) nxt = M_IDLE;
    else if (WDOG_EN && run_old && qc >= WDOG_CYCLES) nxt = M_FAULT;
    else if (m_avgv) begin
      if (m_mode == M_IDLE) nxt = (m_avg < lo) ? M_HEAT : M_COOL;
      else if (m_mode == M_HEAT && m_avg >= hi && m_since >= MIN_HOLD) nxt = M_COOL;
      else if (m_mode == M_COOL && m_avg < lo && m_since >= MIN_HOLD) nxt = M_HEAT;
    end
    if ((nxt == M_HEAT) != m_heat) m_since = 0;
    else if (m_since < MIN_HOLD) m_since++;
    m_heat  = (nxt == M_HEAT);
    m_quiet = (nxt == M_HEAT || nxt == M_COOL) ? qc : 0;
    m_mode  = nxt;
    m_avgv  = 0;
    if (sample_valid) begin
      m_q.push_back(int'(adc_value));
      if (m_q.size() == NSAMP) begin
        sum = 0;
        foreach (m_q[i]) sum += m_q[i];
        m_avg  = sum / NSAMP;
        m_avgv = 1;
        m_q.delete();
      end
    end
  endtask

  task automatic step();
    @(posedge clk48mhz);
    model_edge();
    #1;
    chk("heater_on", heater_on, m_heat);
    chk("fault", fault, (m_mode == M_FAULT));
    chk("avg_valid", avg_valid, m_avgv);
    chk("avg_value", avg_value, m_avg);
  endtask

  task automatic send(input logic [15:0] val, input int gap);
    sample_valid = 1'b1;
    adc_value    = val;
    step();
    sample_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic group(input logic [15:0] val, input int gap);
    repeat (NSAMP) send(val, gap);
  endtask

  initial begin
    int a;
    rstn = 1'b0; sample_valid = 1'b0; adc_value = '0;
    adc_setpoint = 16'd1000; hyst = 8'd16; enable = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_heater", heater_on, 0);
    chk("rst_avg", avg_value, 0);
    chk("rst_fault", fault, 0);
    rstn = 1'b1;
    step();

    // Averaging of 100..400
    send(16'd100, 0); send(16'd200, 0); send(16'd300, 0); send(16'd400, 0);
    chk("avg_250", avg_value, 250);
    chk("avg_250_strobe", avg_valid, 1);
    step();
    chk("avg_strobe_one_cycle", avg_valid, 0);

    // Hysteresis around 1000 +/- 16
    enable = 1'b1;
    group(16'd900, 3);
    chk("hyst_heat", heater_on, 1);
    group(16'd1010, 3);
    chk("hyst_hold_band", heater_on, 1);
    group(16'd1016, 3);
    chk("hyst_cool", heater_on, 0);

    // Minimum hold: second average lands 3 cycles after entering HEAT
    repeat (10) step();
    group(16'd900, 0);
    group(16'd1100, 0);
    step();
    chk("hold_blocks", heater_on, 1);
    group(16'd1100, 3);
    chk("hold_expired_cool", heater_on, 0);

    // Saturation of the low threshold
    enable = 1'b0; step();
    adc_setpoint = 16'd10; hyst = 8'd20; enable = 1'b1;
    group(16'd0, 3);
    chk("lo_sat_no_heat", heater_on, 0);
    group(16'd0, 3);
    chk("lo_sat_still_cool", heater_on, 0);

    // Saturation of the high threshold
    enable = 1'b0; step();
    adc_setpoint = 16'hFFF0; hyst = 8'h20; enable = 1'b1;
    group(16'd100, 3);
    chk("hi_sat_heat", heater_on, 1);
    group(16'hFFFE, 3);
    chk("hi_sat_below", heater_on, 1);
    group(16'hFFFF, 3);
    chk("hi_sat_at_max", heater_on, 0);

    // Watchdog
    enable = 1'b0; step();
    adc_setpoint = 16'd1000; hyst = 8'd16; enable = 1'b1;
    group(16'd500, 1);
    chk("wdog_heat", heater_on, 1);
    repeat (110) step();
    chk("wdog_fault", fault, WDOG_EN);
    chk("wdog_heater", heater_on, !WDOG_EN);
    enable = 1'b0; step();
    chk("wdog_clear", fault, 0);
    chk("wdog_idle_heater", heater_on, 0);

    // Reset discards a partial average
    send(16'd77, 0); send(16'd77, 0);
    rstn = 1'b0; step(); rstn = 1'b1;
    group(16'd500, 0);
    chk("rst_partial_avg", avg_value, 500);
    chk("rst_partial_strobe", avg_valid, 1);

    // Randomized regulation
    enable = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        adc_setpoint = 16'($urandom_range(0, 65535));
        hyst         = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 399) == 0) repeat (120) begin
        sample_valid = 1'b0;
        step();
      end
      enable = ($urandom_range(0, 59) != 0);
      rstn   = ($urandom_range(0, 999) != 0);
      a = int'(adc_setpoint) - 150 + int'($urandom_range(0, 300));
      if (a < 0) a = 0;
      if (a > 65535) a = 65535;
      adc_value    = 16'(a);
      sample_valid = ($urandom_range(0, 2) == 0);
      step();
    end
    rstn = 1'b1; sample_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
